// File: rtl/vscale_dmem_responder.sv
// vscale data-memory responder: one-word-wide data RAM behind the core's
// pipelined dmem port. The address phase is captured into phase registers and
// the data phase runs the following cycle(s), with optional wait states.
// Out-of-range, misaligned or unsupported-size accesses are flagged and dropped.
module vscale_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_dmem_en,
    input  logic        i_dmem_wen,
    input  logic [2:0]  i_dmem_size,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata_delayed,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_wait,
    output logic        o_dmem_badmem_e
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [2:0]  MEM_TYPE_B = 3'd0;
    localparam logic [2:0]  MEM_TYPE_H = 3'd1;
    localparam logic [2:0]  MEM_TYPE_W = 3'd2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ph_state_t;

    // Lanes touched by a store; unsupported sizes touch nothing.
    function automatic logic [3:0] f_byte_en(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            MEM_TYPE_B: f_byte_en = 4'b0001 << lane;
            MEM_TYPE_H: f_byte_en = 4'b0011 << {lane[1], 1'b0};
            MEM_TYPE_W: f_byte_en = 4'b1111;
            default:    f_byte_en = 4'b0000;
        endcase
    endfunction

    // An access is illegal if its size is unsupported or not naturally aligned.
    function automatic logic f_size_bad(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            MEM_TYPE_B: f_size_bad = 1'b0;
            MEM_TYPE_H: f_size_bad = lane[0];
            MEM_TYPE_W: f_size_bad = (lane != 2'b00);
            default:    f_size_bad = 1'b1;
        endcase
    endfunction

    ph_state_t   r_state;
    ph_state_t   w_state_nxt;
    logic        r_ph_wen;
    logic [2:0]  r_ph_size;
    logic [31:0] r_ph_addr;
    logic [3:0]  r_wcnt;
    logic [3:0]  w_wcnt_nxt;
    logic        w_accept;
    logic        w_ph_vld;
    logic [31:0] w_offset;
    logic [AW-1:0] w_idx;
    logic        w_bad;
    logic        w_wait_pend;
    logic        w_wait;
    logic        w_commit;
    logic [3:0]  w_be;
    logic [31:0] r_mem [DEPTH_WORDS];

    assign w_ph_vld = (r_state == ST_ACTIVE);
    assign w_offset = r_ph_addr - BASE_ADDR;
    assign w_idx    = w_offset[AW+1:2];
    assign w_bad    = (w_offset >= SPAN) | f_size_bad(r_ph_size, w_offset[1:0]);
    assign w_be     = f_byte_en(r_ph_size, w_offset[1:0]);

    generate
        if (WAIT_CYCLES == 0) begin : g_nowait
            assign w_wait_pend = 1'b0;
        end else begin : g_wait
            localparam logic [3:0] WAIT_MAX = 4'(WAIT_CYCLES);
            assign w_wait_pend = (r_wcnt < WAIT_MAX);
        end
    endgenerate

    // Good accesses stall until the wait counter reaches the programmed count.
    assign w_wait   = w_ph_vld & ~w_bad & w_wait_pend;
    assign w_commit = w_ph_vld & r_ph_wen & ~w_bad & ~w_wait;

    // Next phase state: accept a new request only once the current one completes.
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_accept    = 1'b0;
        if (w_wait) begin
            w_wcnt_nxt = r_wcnt + 4'd1;
        end else begin
            w_accept    = i_dmem_en;
            w_wcnt_nxt  = 4'd0;
            w_state_nxt = i_dmem_en ? ST_ACTIVE : ST_IDLE;
        end
    end

    // Phase state, wait counter and captured address-phase fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_wcnt    <= 4'd0;
            r_ph_wen  <= 1'b0;
            r_ph_size <= 3'd0;
            r_ph_addr <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_accept) begin
                r_ph_wen  <= i_dmem_wen;
                r_ph_size <= i_dmem_size;
                r_ph_addr <= i_dmem_addr;
            end
        end
    end

    // Commit the enabled lanes of a good store at the edge ending its data phase.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= i_dmem_wdata_delayed[8*b +: 8];
                end
            end
        end
    end

    // Data-phase outputs, driven only from phase state so there is no input-to-output path.
    always_comb begin
        o_dmem_wait     = w_wait;
        o_dmem_badmem_e = w_ph_vld & w_bad;
        if (w_ph_vld & ~r_ph_wen & ~w_bad & ~w_wait) begin
            o_dmem_rdata = r_mem[w_idx];
        end else begin
            o_dmem_rdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Self-checking bench for vscale_dmem_responder: two instances (0 and 3 wait
// states) driven by a pipelined access sequencer and checked against a
// byte-array memory model plus hand-written expected values.
module tb_vscale_dmem_responder;

    localparam int DEPTH  = 4096;
    localparam int NBYTES = DEPTH * 4;
    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;
    localparam logic [2:0] SZ_D = 3'd3;

    typedef struct {
        logic        wen;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        gap;
        logic        use_exp;
        logic [31:0] exp_rdata;
        logic        exp_bad;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_s    [2];
    logic        wen_s   [2];
    logic [2:0]  size_s  [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        wait_s  [2];
    logic        bad_s   [2];
    int          wait_cfg [2];
    logic [7:0]  mdl [2][NBYTES];
    op_t         op_q [$];
    op_t         table_v [$];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    vscale_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_dmem_en(en_s[0]), .i_dmem_wen(wen_s[0]), .i_dmem_size(size_s[0]),
        .i_dmem_addr(addr_s[0]), .i_dmem_wdata_delayed(wdata_s[0]),
        .o_dmem_rdata(rdata_s[0]), .o_dmem_wait(wait_s[0]), .o_dmem_badmem_e(bad_s[0])
    );

    vscale_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_dmem_en(en_s[1]), .i_dmem_wen(wen_s[1]), .i_dmem_size(size_s[1]),
        .i_dmem_addr(addr_s[1]), .i_dmem_wdata_delayed(wdata_s[1]),
        .o_dmem_rdata(rdata_s[1]), .o_dmem_wait(wait_s[1]), .o_dmem_badmem_e(bad_s[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Legality from first principles: in range, supported size, naturally aligned.
    function automatic logic model_bad(input logic [2:0] size, input logic [31:0] addr);
        if (addr >= 32'(NBYTES)) return 1'b1;
        if (size > SZ_W) return 1'b1;
        if ((addr % (32'd1 << size)) != 32'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_word(input int sel, input logic [31:0] addr);
        int a;
        a = int'(addr) & ~3;
        return {mdl[sel][a+3], mdl[sel][a+2], mdl[sel][a+1], mdl[sel][a]};
    endfunction

    task automatic model_store(input int sel, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
        int b;
        for (int i = 0; i < (1 << size); i++) begin
            b = int'(addr) + i;
            mdl[sel][b] = wdata[8*(b % 4) +: 8];
        end
    endtask

    function automatic op_t mk(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_r, input logic exp_b);
        op_t o;
        o.wen = wen; o.size = size; o.addr = addr; o.wdata = wdata; o.gap = 1'b0;
        o.use_exp = 1'b1; o.exp_rdata = exp_r; o.exp_bad = exp_b;
        return o;
    endfunction

    function automatic op_t mk_rand(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic gap);
        op_t o;
        o = mk(wen, size, addr, wdata, 32'h0, 1'b0);
        o.use_exp = 1'b0;
        o.gap = gap;
        return o;
    endfunction

    // Issue op_q to one DUT as a pipelined stream; caller enters just after a rising edge.
    task automatic run_seq(input int sel);
        op_t  dp;
        logic have_dp;
        logic exp_b;
        logic [31:0] exp_r;
        int   k, waits, budget;
        have_dp = 1'b0; k = 0; waits = 0; budget = 0;
        while ((k < op_q.size() || have_dp) && budget < 5000) begin
            budget++;
            if (k < op_q.size() && !op_q[k].gap) begin
                en_s[sel] = 1'b1; wen_s[sel] = op_q[k].wen;
                size_s[sel] = op_q[k].size; addr_s[sel] = op_q[k].addr;
            end else begin
                en_s[sel] = 1'b0; wen_s[sel] = 1'b0; size_s[sel] = 3'd0; addr_s[sel] = 32'h0;
            end
            wdata_s[sel] = have_dp ? dp.wdata : 32'h0;
            @(negedge clk);
            if (have_dp && wait_s[sel]) begin
                waits++;
                chk("rdata_during_wait", rdata_s[sel], 32'h0);
                @(posedge clk); #1;
                continue;
            end
            if (have_dp) begin
                exp_b = dp.use_exp ? dp.exp_bad : model_bad(dp.size, dp.addr);
                exp_r = dp.use_exp ? dp.exp_rdata
                                   : ((dp.wen || exp_b) ? 32'h0 : model_word(sel, dp.addr));
                chk("badmem_e", 32'(bad_s[sel]), 32'(exp_b));
                chk("rdata", rdata_s[sel], exp_r);
                chk("wait_cycles", 32'(waits), exp_b ? 32'd0 : 32'(wait_cfg[sel]));
                if (dp.wen && !model_bad(dp.size, dp.addr)) model_store(sel, dp.size, dp.addr, dp.wdata);
            end else begin
                chk("idle_outputs", {rdata_s[sel][29:0], wait_s[sel], bad_s[sel]}, 32'h0);
            end
            waits = 0;
            if (k < op_q.size() && !op_q[k].gap) begin
                dp = op_q[k]; have_dp = 1'b1; k++;
            end else begin
                have_dp = 1'b0;
                if (k < op_q.size()) op_q[k].gap = 1'b0;
            end
            @(posedge clk); #1;
        end
        if (budget >= 5000) chk("seq_budget_expired", 32'(budget), 32'd0);
        en_s[sel] = 1'b0; wen_s[sel] = 1'b0; wdata_s[sel] = 32'h0;
        op_q.delete();
    endtask

    task automatic gen_random(input int n);
        logic [2:0]  sz;
        logic [31:0] r, a, wd;
        for (int i = 0; i < n; i++) begin
            sz = ($urandom_range(0, 19) == 0) ? SZ_D : 3'($urandom_range(0, 2));
            a  = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 29) == 0) a = 32'(NBYTES) + 32'($urandom_range(0, 255));
            r  = $urandom;
            wd = (sz == SZ_B) ? {4{r[7:0]}} : ((sz == SZ_H) ? {2{r[15:0]}} : r);
            op_q.push_back(mk_rand(1'($urandom_range(0, 1)), sz, a, wd, ($urandom_range(0, 3) == 0)));
        end
    endtask

    initial begin
        wait_cfg[0] = 0;
        wait_cfg[1] = 3;
        for (int s = 0; s < 2; s++) begin
            en_s[s] = 1'b0; wen_s[s] = 1'b0; size_s[s] = 3'd0; addr_s[s] = 32'h0; wdata_s[s] = 32'h0;
        end

        // Directed table: stores, lane merges, misaligned/out-of-range/bad-size, boundary word.
        table_v.push_back(mk(1'b1, SZ_W, 32'h0000, 32'h01020304, 32'h0, 1'b0));
        table_v.push_back(mk(1'b1, SZ_W, 32'h0010, 32'h11223344, 32'h0, 1'b0));
        table_v.push_back(mk(1'b0, SZ_W, 32'h0010, 32'h0,        32'h11223344, 1'b0));
        table_v.push_back(mk(1'b1, SZ_B, 32'h0013, 32'hAAAAAAAA, 32'h0, 1'b0));
        table_v.push_back(mk(1'b0, SZ_W, 32'h0010, 32'h0,        32'hAA223344, 1'b0));
        table_v.push_back(mk(1'b1, SZ_H, 32'h0012, 32'hBEEFBEEF, 32'h0, 1'b0));
        table_v.push_back(mk(1'b0, SZ_W, 32'h0010, 32'h0,        32'hBEEF3344, 1'b0));
        table_v.push_back(mk(1'b0, SZ_W, 32'h0002, 32'h0,        32'h0, 1'b1));
        table_v.push_back(mk(1'b1, SZ_H, 32'h0001, 32'h55555555, 32'h0, 1'b1));
        table_v.push_back(mk(1'b0, SZ_W, 32'h0000, 32'h0,        32'h01020304, 1'b0));
        table_v.push_back(mk(1'b0, SZ_W, 32'h4000, 32'h0,        32'h0, 1'b1));
        table_v.push_back(mk(1'b1, SZ_D, 32'h0010, 32'h77777777, 32'h0, 1'b1));
        table_v.push_back(mk(1'b0, SZ_W, 32'h0010, 32'h0,        32'hBEEF3344, 1'b0));
        table_v.push_back(mk(1'b1, SZ_B, 32'h0011, 32'h99999999, 32'h0, 1'b0));
        table_v.push_back(mk(1'b0, SZ_W, 32'h0010, 32'h0,        32'hBEEF9944, 1'b0));
        table_v.push_back(mk(1'b1, SZ_H, 32'h0010, 32'h12341234, 32'h0, 1'b0));
        table_v.push_back(mk(1'b0, SZ_W, 32'h0010, 32'h0,        32'hBEEF1234, 1'b0));
        table_v.push_back(mk(1'b1, SZ_W, 32'h3FFC, 32'hA5A5F00F, 32'h0, 1'b0));
        table_v.push_back(mk(1'b0, SZ_W, 32'h3FFC, 32'h0,        32'hA5A5F00F, 1'b0));
        table_v.push_back(mk(1'b0, SZ_B, 32'h0013, 32'h0,        32'hBEEF1234, 1'b0));

        // Reset state.
        #12;
        for (int s = 0; s < 2; s++) begin
            chk("reset_rdata", rdata_s[s], 32'h0);
            chk("reset_wait", 32'(wait_s[s]), 32'h0);
            chk("reset_badmem", 32'(bad_s[s]), 32'h0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table on both wait configurations.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < table_v.size(); i++) op_q.push_back(table_v[i]);
            run_seq(s);
        end

        // Reset mid-wait abandons the store; previous contents survive.
        op_q.push_back(mk(1'b1, SZ_W, 32'h20, 32'h12345678, 32'h0, 1'b0));
        run_seq(1);
        en_s[1] = 1'b1; wen_s[1] = 1'b1; size_s[1] = SZ_W; addr_s[1] = 32'h20;
        @(posedge clk); #1;
        en_s[1] = 1'b0; wen_s[1] = 1'b0; wdata_s[1] = 32'hDEADBEEF;
        @(negedge clk);
        chk("abort_wait_before_reset", 32'(wait_s[1]), 32'h1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_wait_after_reset", 32'(wait_s[1]), 32'h0);
        chk("abort_bad_after_reset", 32'(bad_s[1]), 32'h0);
        chk("abort_rdata_after_reset", rdata_s[1], 32'h0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1; wdata_s[1] = 32'h0;
        @(posedge clk); #1;
        op_q.push_back(mk(1'b0, SZ_W, 32'h20, 32'h0, 32'h12345678, 1'b0));
        run_seq(1);

        // Randomized B/H/W mix against the byte model, after initialising the region.
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 17; w++)
                op_q.push_back(mk_rand(1'b1, SZ_W, 32'h100 + 32'(w * 4), $urandom, 1'b0));
            gen_random(150);
            run_seq(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
